// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/double-click pulses.
// Double-click detection (WAIT_SECOND / SECOND_HELD) is built only when BUTTON_DOUBLE_CLICK_EN is defined.
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES   = 1000,
  parameter int DOUBLE_CLICK_CYCLES = 300,
  parameter int CNT_WIDTH           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRESSED     = 3'd1,
    S_LONG_HELD   = 3'd2,
    S_WAIT_SECOND = 3'd3,
    S_SECOND_HELD = 3'd4
  } state_e;

  if (LONG_PRESS_CYCLES < 2 || longint'(LONG_PRESS_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_chk_long
    $error("LONG_PRESS_CYCLES out of range for CNT_WIDTH");
  end
  if (DOUBLE_CLICK_CYCLES < 2 || longint'(DOUBLE_CLICK_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_chk_dbl
    $error("DOUBLE_CLICK_CYCLES out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_TC = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
`ifdef BUTTON_DOUBLE_CLICK_EN
  localparam logic [CNT_WIDTH-1:0] DBL_TC  = CNT_WIDTH'(DOUBLE_CLICK_CYCLES - 1);
`endif

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic                 btn_q, btn_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
`ifdef BUTTON_DOUBLE_CLICK_EN
  logic                 dbl_q, dbl_d;
`endif
  logic                 rise, fall;

  assign rise = button_in & ~btn_q;
  assign fall = ~button_in & btn_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    btn_d     = button_in;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    dbl_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
          timer_d = '0;
        end
      end
      S_PRESSED: begin
        // Release outranks the long-press threshold when both land on the same edge.
        if (fall) begin
          release_d = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
          state_d   = S_WAIT_SECOND;
          timer_d   = '0;
`else
          short_d   = 1'b1;
          state_d   = S_IDLE;
`endif
        end else if (timer_q == LONG_TC) begin
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`ifdef BUTTON_DOUBLE_CLICK_EN
      S_WAIT_SECOND: begin
        // A second press on the timeout edge still counts as a double click.
        if (rise) begin
          press_d = 1'b1;
          dbl_d   = 1'b1;
          state_d = S_SECOND_HELD;
        end else if (timer_q == DBL_TC) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SECOND_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // btn_q resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
      dbl_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
`ifdef BUTTON_DOUBLE_CLICK_EN
      dbl_q     <= dbl_d;
`endif
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
`ifdef BUTTON_DOUBLE_CLICK_EN
  assign double_click  = dbl_q;
`else
  assign double_click  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with L=20, D=10; expectations follow BUTTON_DOUBLE_CLICK_EN.
module tb_button_event_decoder;
  localparam int L = 20;
  localparam int D = 10;
`ifdef BUTTON_DOUBLE_CLICK_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, button_in;
  logic press_pulse, release_pulse, short_press, long_press, double_click;

  button_event_decoder #(
    .LONG_PRESS_CYCLES(L), .DOUBLE_CLICK_CYCLES(D), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .short_press(short_press), .long_press(long_press), .double_click(double_click)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0;
  int t_press = 0, t_rel = 0, t_short = 0, t_long = 0, t_dbl = 0;
  always @(negedge clk) begin
    if (press_pulse === 1'b1)   begin n_press++; t_press = cyc; end
    if (release_pulse === 1'b1) begin n_rel++;   t_rel   = cyc; end
    if (short_press === 1'b1)   begin n_short++; t_short = cyc; end
    if (long_press === 1'b1)    begin n_long++;  t_long  = cyc; end
    if (double_click === 1'b1)  begin n_dbl++;   t_dbl   = cyc; end
    if (int'(short_press === 1'b1) + int'(long_press === 1'b1) + int'(double_click === 1'b1) > 1)
      n_multi++;
  end

  int checks = 0, passed = 0;
  int bp, br, bs, bl, bd, e;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    bp = n_press; br = n_rel; bs = n_short; bl = n_long; bd = n_dbl;
  endtask

  task automatic do_reset();
    reset = 1'b0; button_in = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    reset = 1'b0; button_in = 1'b1;
    step(3);
    checks++; if ({press_pulse, release_pulse, short_press, long_press, double_click} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000",
               {press_pulse, release_pulse, short_press, long_press, double_click});
    else passed++;
    reset = 1'b1;
    snap();
    step(50);
    checks++; if ((n_press - bp) + (n_long - bl) + (n_short - bs) + (n_dbl - bd) !== 0)
      $display("FAIL held_through_reset_events: got %0d expected 0",
               (n_press - bp) + (n_long - bl) + (n_short - bs) + (n_dbl - bd));
    else passed++;
    button_in = 1'b0;
    step(5);
    checks++; if ((n_rel - br) !== 0)
      $display("FAIL idle_fall_release: got %0d expected 0", n_rel - br);
    else passed++;
    e = cyc;
    button_in = 1'b1;
    step(3);
    checks++; if ((n_press - bp) !== 1)
      $display("FAIL repress_count: got %0d expected 1", n_press - bp);
    else passed++;
    checks++; if (t_press !== e + 1)
      $display("FAIL press_latency: got %0d expected %0d", t_press, e + 1);
    else passed++;
    button_in = 1'b0;
    step(20);
  endtask

  task automatic test_short_click();
    do_reset();
    snap();
    button_in = 1'b1;
    step(5);
    e = cyc;
    button_in = 1'b0;
    step(20);
    checks++; if ((n_press - bp) !== 1 || (n_rel - br) !== 1)
      $display("FAIL short_press_rel_cnt: got %0d/%0d expected 1/1", n_press - bp, n_rel - br);
    else passed++;
    checks++; if (t_rel !== e + 1)
      $display("FAIL release_latency: got %0d expected %0d", t_rel, e + 1);
    else passed++;
    checks++; if ((n_short - bs) !== 1)
      $display("FAIL short_cnt: got %0d expected 1", n_short - bs);
    else passed++;
    checks++; if (t_short - t_rel !== (DC_EN ? D : 0))
      $display("FAIL short_delay: got %0d expected %0d", t_short - t_rel, DC_EN ? D : 0);
    else passed++;
    checks++; if ((n_long - bl) !== 0 || (n_dbl - bd) !== 0)
      $display("FAIL short_stray_long_dbl: got %0d/%0d expected 0/0", n_long - bl, n_dbl - bd);
    else passed++;
  endtask

  task automatic test_long_press();
    do_reset();
    snap();
    button_in = 1'b1;
    step(30);
    checks++; if ((n_long - bl) !== 1)
      $display("FAIL long_cnt: got %0d expected 1", n_long - bl);
    else passed++;
    checks++; if (t_long - t_press !== L)
      $display("FAIL long_delay: got %0d expected %0d", t_long - t_press, L);
    else passed++;
    button_in = 1'b0;
    step(20);
    checks++; if ((n_rel - br) !== 1 || (n_short - bs) !== 0)
      $display("FAIL long_release_short: got %0d/%0d expected 1/0", n_rel - br, n_short - bs);
    else passed++;
  endtask

  task automatic test_long_boundary();
    do_reset();
    snap();
    button_in = 1'b1;
    step(L);
    button_in = 1'b0;
    step(20);
    checks++; if ((n_long - bl) !== 0 || (n_rel - br) !== 1 || (n_short - bs) !== 1)
      $display("FAIL release_at_threshold: got long %0d rel %0d short %0d expected 0 1 1",
               n_long - bl, n_rel - br, n_short - bs);
    else passed++;
    snap();
    button_in = 1'b1;
    step(L + 1);
    button_in = 1'b0;
    step(20);
    checks++; if ((n_long - bl) !== 1 || (n_short - bs) !== 0)
      $display("FAIL release_after_threshold: got long %0d short %0d expected 1 0",
               n_long - bl, n_short - bs);
    else passed++;
  endtask

  task automatic test_double_click();
    do_reset();
    snap();
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(4);
    e = cyc;
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(20);
    checks++; if ((n_press - bp) !== 2 || (n_rel - br) !== 2)
      $display("FAIL dbl_press_rel_cnt: got %0d/%0d expected 2/2", n_press - bp, n_rel - br);
    else passed++;
    checks++; if ((n_dbl - bd) !== (DC_EN ? 1 : 0))
      $display("FAIL dbl_cnt: got %0d expected %0d", n_dbl - bd, DC_EN ? 1 : 0);
    else passed++;
    checks++; if ((n_short - bs) !== (DC_EN ? 0 : 2))
      $display("FAIL dbl_short_cnt: got %0d expected %0d", n_short - bs, DC_EN ? 0 : 2);
    else passed++;
    checks++; if (t_press !== e + 1)
      $display("FAIL second_press_time: got %0d expected %0d", t_press, e + 1);
    else passed++;
    checks++; if (DC_EN && t_dbl !== t_press)
      $display("FAIL dbl_with_press: got %0d expected %0d", t_dbl, t_press);
    else passed++;
  endtask

  task automatic test_dc_boundary();
    do_reset();
    snap();
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(D);
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(20);
    checks++; if ((n_dbl - bd) !== (DC_EN ? 1 : 0) || (n_short - bs) !== (DC_EN ? 0 : 2))
      $display("FAIL rise_on_timeout: got dbl %0d short %0d expected %0d %0d",
               n_dbl - bd, n_short - bs, DC_EN ? 1 : 0, DC_EN ? 0 : 2);
    else passed++;
    snap();
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(D + 1);
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(20);
    checks++; if ((n_dbl - bd) !== 0 || (n_short - bs) !== 2)
      $display("FAIL rise_after_timeout: got dbl %0d short %0d expected 0 2",
               n_dbl - bd, n_short - bs);
    else passed++;
  endtask

  task automatic test_reset_wait();
    do_reset();
    snap();
    button_in = 1'b1; step(3);
    button_in = 1'b0; step(4);
    reset = 1'b0;
    step(1);
    checks++; if ({press_pulse, release_pulse, short_press, long_press, double_click} !== 5'b0)
      $display("FAIL midop_reset_outputs: got %b expected 00000",
               {press_pulse, release_pulse, short_press, long_press, double_click});
    else passed++;
    reset = 1'b1;
    step(30);
    checks++; if ((n_short - bs) !== (DC_EN ? 0 : 1))
      $display("FAIL midop_reset_short: got %0d expected %0d", n_short - bs, DC_EN ? 0 : 1);
    else passed++;
    checks++; if ((n_press - bp) !== 1 || (n_rel - br) !== 1)
      $display("FAIL midop_reset_press_rel: got %0d/%0d expected 1/1", n_press - bp, n_rel - br);
    else passed++;
  endtask

  initial begin
    reset = 1'b0;
    button_in = 1'b0;
    test_reset();
    test_short_click();
    test_long_press();
    test_long_boundary();
    test_double_click();
    test_dc_boundary();
    test_reset_wait();
    checks++; if (n_multi !== 0)
      $display("FAIL exclusive_events: got %0d overlap cycles expected 0", n_multi);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
